parity_stream: RTL
==================

# parity_stream

Streaming, parametrised parity generator/checker. Accumulates the parity of a frame of WIDTH-bit words arriving over a valid/ready stream and presents one registered result per frame: parity bit, word count and a check flag. Replaces the single-word combinational XOR parity tree wherever parity must span multi-word frames, exclude selected bit lanes, or verify a received parity bit.

## Interface
- WIDTH, 8: data word width in bits (1..64).
- MASK, {WIDTH{1'b1}}: lane mask; only bits with MASK[i]=1 contribute to parity.
- ODD, 0: 0 = even parity (result is XOR of masked bits), 1 = odd parity (result inverted).
- CNT_W, 8: width of the word counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  data word.
- in_last  input  1  word is the last of its frame.
- chk_en  input  1  sampled with the last word; 1 = check mode.
- chk_par  input  1  received parity bit, sampled with the last word.
- out_valid  output  1  frame result valid.
- out_ready  input  1  consumer accepts result.
- out_parity  output  1  frame parity per ODD.
- out_error  output  1  check mode only: out_parity != chk_par; 0 in generate mode.
- out_count  output  CNT_W  words in frame, saturating at 2^CNT_W-1.
- out_ovf  output  1  frame length exceeded 2^CNT_W-1 words.

## Operation
- Two states: ACCUM (collecting words) and HOLD (result presented).
- in_ready = (state == ACCUM). Word transfer = in_valid & in_ready on a rising edge.
- ACCUM, non-last transfer: acc <= acc ^ ^(in_data & MASK); cnt <= sat(cnt+1); ovf set if cnt already at max.
- ACCUM, last transfer: final p = acc ^ ^(in_data & MASK) ^ ODD; out_parity <= p; out_count <= sat(cnt+1); out_ovf <= ovf | (cnt at max); out_error <= chk_en & (p != chk_par); out_valid <= 1; acc, cnt, ovf cleared; go to HOLD.
- HOLD: outputs frozen; on out_valid & out_ready, out_valid <= 0, go to ACCUM. Words are not accepted during HOLD, including the acceptance cycle.
- Single-word frame (in_last on the first word) is legal; count = 1.
- Reset (any time, including mid-frame or in HOLD): state ACCUM, acc, cnt, ovf, out_valid, out_parity, out_error, out_count, out_ovf all 0. Partial frame discarded; no result emitted for it.
- in_data, in_last, chk_en, chk_par are ignored when no transfer occurs.

## Timing
- Latency: out_valid rises on the clock edge that accepts the last word; result visible in the following cycle.
- in_ready falls combinationally with state; it is 0 from that edge until the edge that accepts the result.
- Throughput: N-word frame occupies N input cycles + at least 1 HOLD cycle; maximum rate one frame per N+1 cycles.
- out_* are registers, stable while out_valid=1 and out_ready=0 (AXI-style: out_valid never drops without acceptance).
- in_valid may be deasserted between words of a frame with no effect on the result.
- Counter saturation: with CNT_W=2, a 5-word frame gives out_count=3, out_ovf=1; parity still covers all 5 words.

## Test plan
- WIDTH=8, MASK=8'hEF, even: sweep all 256 single-word frames, out_ready=1 -> out_parity = XOR of bits {0,1,2,3,5,6,7}; e.g. 8'h10 -> 0, 8'h11 -> 1, 8'hFF -> 1; out_count=1.
- Multi-word, full mask: frame 8'h01, 8'h03, 8'h80 with idle gaps -> out_parity=0, out_count=3; with ODD=1 -> 1.
- Check mode: frame 8'h07 with chk_en=1, chk_par=1 -> out_error=0; chk_par=0 -> out_error=1; chk_en=0 -> out_error=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> out_* stable, in_ready=0 with in_valid=1 (no word consumed); raise out_ready -> next frame accepted from the following cycle.
- Saturation: CNT_W=2, 5-word frame of 8'h01 -> out_count=3, out_ovf=1, out_parity=1; next 1-word frame -> out_ovf=0.
- Reset mid-frame: 2 words of 8'h01, assert rst asynchronously -> out_valid=0 immediately, in_ready=1 after release; next frame 8'h01 alone -> out_parity=1, out_count=1.

Source files
------------

// File: rtl/parity_stream.sv
// Streaming parity generator/checker: folds the masked parity of every word in a
// valid/ready frame and holds one registered result per frame until it is accepted.
module parity_stream #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] MASK  = {WIDTH{1'b1}},
    parameter bit               ODD   = 1'b0,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             chk_en,
    input  logic             chk_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic masked_parity(input logic [WIDTH-1:0] d);
        return ^(d & MASK);
    endfunction

    state_t           state_r, state_s;
    logic             acc_r, acc_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             ovf_r, ovf_s;
    logic             out_valid_r, out_valid_s;
    logic             out_parity_r, out_parity_s;
    logic             out_error_r, out_error_s;
    logic [CNT_W-1:0] out_count_r, out_count_s;
    logic             out_ovf_r, out_ovf_s;

    logic             xfer_s;
    logic             cnt_at_max_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             frame_par_s;

    assign in_ready     = (state_r == ACCUM);
    assign xfer_s       = in_valid & (state_r == ACCUM);
    assign cnt_at_max_s = (cnt_r == CNT_MAX);
    assign cnt_inc_s    = cnt_at_max_s ? CNT_MAX : (cnt_r + CNT_ONE);
    assign frame_par_s  = acc_r ^ masked_parity(in_data) ^ ODD;

    // Next-state and next-result logic for the accumulate/hold handshake.
    always_comb begin
        state_s      = state_r;
        acc_s        = acc_r;
        cnt_s        = cnt_r;
        ovf_s        = ovf_r;
        out_valid_s  = out_valid_r;
        out_parity_s = out_parity_r;
        out_error_s  = out_error_r;
        out_count_s  = out_count_r;
        out_ovf_s    = out_ovf_r;
        case (state_r)
            ACCUM: begin
                if (xfer_s && in_last) begin
                    out_parity_s = frame_par_s;
                    out_count_s  = cnt_inc_s;
                    out_ovf_s    = ovf_r | cnt_at_max_s;
                    out_error_s  = chk_en & (frame_par_s != chk_par);
                    out_valid_s  = 1'b1;
                    acc_s        = 1'b0;
                    cnt_s        = {CNT_W{1'b0}};
                    ovf_s        = 1'b0;
                    state_s      = HOLD;
                end else if (xfer_s) begin
                    acc_s = acc_r ^ masked_parity(in_data);
                    cnt_s = cnt_inc_s;
                    ovf_s = ovf_r | cnt_at_max_s;
                end else begin
                    state_s = ACCUM;
                end
            end
            HOLD: begin
                // out_valid is always high here, so out_ready alone completes the handshake.
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = ACCUM;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = ACCUM;
            end
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ACCUM;
            acc_r        <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            ovf_r        <= 1'b0;
            out_valid_r  <= 1'b0;
            out_parity_r <= 1'b0;
            out_error_r  <= 1'b0;
            out_count_r  <= {CNT_W{1'b0}};
            out_ovf_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            cnt_r        <= cnt_s;
            ovf_r        <= ovf_s;
            out_valid_r  <= out_valid_s;
            out_parity_r <= out_parity_s;
            out_error_r  <= out_error_s;
            out_count_r  <= out_count_s;
            out_ovf_r    <= out_ovf_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_parity = out_parity_r;
    assign out_error  = out_error_r;
    assign out_count  = out_count_r;
    assign out_ovf    = out_ovf_r;

endmodule
